imem_responder: RTL and testbench

//   Instruction-memory responder on the far side of the fetch interface.

---
 rtl/imem_responder.sv | 191 +++++++++++++++++++
 tb/tb_imem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for a fetch unit.
//
// Takes 16-bit fetch requests over valid/ready and returns the little-endian
// word {mem[a+1], mem[a]} after LATENCY pipeline stages, through a small
// response FIFO. The FIFO depth is also the credit limit: in-flight stages
// plus FIFO entries never exceed FIFO_DEPTH, so the FIFO cannot overflow.
// A byte-wide load port writes program memory. A flush drops all in-flight
// and queued responses.
//
// Optional feature macro: IMEM_STATS_EN adds saturating counters for
// delivered responses (stat_served) and backpressure cycles (stat_stall).
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready        fetch request handshake
//   req_addr [15:0]            byte address of the low byte
//   rsp_valid/rsp_ready        response handshake
//   rsp_data [15:0]            {mem[a+1], mem[a]}, zero when rsp_valid is low
//   flush                      drop everything in flight and queued
//   ld_en/ld_addr/ld_data      program-load byte write
//   stat_served/stat_stall     IMEM_STATS_EN only

module imem_responder #(
    parameter int unsigned MEM_SIZE   = 65536,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    input  logic        flush,
    input  logic        ld_en,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_data
`ifdef IMEM_STATS_EN
    ,
    output logic [15:0] stat_served,
    output logic [15:0] stat_stall
`endif
);

    localparam int unsigned AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = $clog2(LATENCY + FIFO_DEPTH + 1);

    localparam logic [CW-1:0] DepthC   = CW'(FIFO_DEPTH);
    localparam logic [OW-1:0] DepthO   = OW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LastPtr  = PW'(FIFO_DEPTH - 1);

    // Program memory (not reset)
    logic [7:0] mem [MEM_SIZE];

    // Read pipeline
    logic [LATENCY-1:0] stg_valid_q;
    logic [15:0]        stg_data_q [LATENCY];

    // Response FIFO
    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [AW-1:0] rd_lo, rd_hi, ld_idx;
    logic [OW-1:0] occupancy;
    logic          accept, push, pop, full;

    assign rd_lo  = req_addr[AW-1:0];
    assign rd_hi  = rd_lo + AW'(1);   // wraps the last byte to byte 0
    assign ld_idx = ld_addr[AW-1:0];

    assign rsp_valid = (count_q != '0);
    assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr_q] : 16'h0000;
    assign pop       = rsp_valid & rsp_ready;
    assign full      = (count_q == DepthC);
    // The last stage pushes at its edge; a flush at that edge discards it.
    assign push      = stg_valid_q[LATENCY-1] & ~flush;
    assign accept    = req_valid & req_ready;

    always_comb begin
        occupancy = OW'(count_q);
        for (int i = 0; i < LATENCY; i++) begin
            occupancy = occupancy + OW'(stg_valid_q[i]);
        end
    end

    // A pop at full occupancy frees the credit in the same cycle.
    assign req_ready = rst & ~flush & ~ld_en &
                       ((occupancy < DepthO) | ((occupancy == DepthO) & pop));

    // Memory write port; ld_en blocks accepts, so no same-edge read/write.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end
    end

    // Stage valids
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_valid_q <= '0;
        end else if (flush) begin
            stg_valid_q <= '0;
        end else begin
            stg_valid_q[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                stg_valid_q[i] <= stg_valid_q[i-1];
            end
        end
    end

    // Stage data: both bytes are captured at the accept edge
    always_ff @(posedge clk) begin
        if (accept) begin
            stg_data_q[0] <= {mem[rd_hi], mem[rd_lo]};
        end
        for (int i = 1; i < LATENCY; i++) begin
            stg_data_q[i] <= stg_data_q[i-1];
        end
    end

    // FIFO control
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // On full with a simultaneous pop, wr_ptr equals rd_ptr; the head was
    // already presented this cycle, so overwriting it is safe.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= stg_data_q[LATENCY-1];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
                                    !(push && full && !pop));

`ifdef IMEM_STATS_EN
    // Cleared by reset only; a pop during flush still counts as delivered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_served <= 16'h0000;
            stat_stall  <= 16'h0000;
        end else begin
            if (pop && (stat_served != 16'hFFFF)) begin
                stat_served <= stat_served + 16'h0001;
            end
            if (rsp_valid && !rsp_ready && (stat_stall != 16'hFFFF)) begin
                stat_stall <= stat_stall + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: stimulus pushes expected words into a
// queue at accept; a negedge monitor pops and compares on every handshake.

module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        flush;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
`ifdef IMEM_STATS_EN
    logic [15:0] stat_served;
    logic [15:0] stat_stall;
`endif

    imem_responder #(
        .MEM_SIZE   (65536),
        .LATENCY    (2),
        .FIFO_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .flush      (flush),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data)
`ifdef IMEM_STATS_EN
        ,
        .stat_served(stat_served),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    // Returns at posedge+1 right after the accept edge.
    task automatic fetch(input logic [15:0] a, input logic [15:0] exp);
        bit got = 0;
        req_valid = 1'b1;
        req_addr  = a;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1;
                break;
            end
        end
        if (got) exp_q.push_back(exp);
        else chk("fetch_accept_timeout", 32'd0, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp_valid();
        bit got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("rsp_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_left", exp_q.size(), 32'd0);
        tick();
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rsp_unexpected: got %h, expected no response (t=%0t)",
                         rsp_data, $time);
            end else begin
                chk("rsp_data", rsp_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int highs;
        rst = 1'b0; req_valid = 1'b1; req_addr = '0; rsp_ready = 1'b1;
        flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_data", rsp_data, 16'h0000);
        chk("reset_req_ready", req_ready, 1'b0);
`ifdef IMEM_STATS_EN
        chk("reset_stat_served", stat_served, 16'h0000);
        chk("reset_stat_stall", stat_stall, 16'h0000);
`endif
        req_valid = 1'b0;
        rst = 1'b1;
        tick();

        // Basic fetch with latency LATENCY+1
        load(16'h0000, 8'h12); load(16'h0001, 8'h34);
        load(16'h0002, 8'h56); load(16'h0003, 8'h78);
        load(16'h0004, 8'h9A); load(16'h0005, 8'hBC);
        fetch(16'h0000, 16'h3412);
        @(negedge clk); chk("lat_c1_valid", rsp_valid, 1'b0);
        @(negedge clk); chk("lat_c2_valid", rsp_valid, 1'b0);
        @(negedge clk); chk("lat_c3_valid", rsp_valid, 1'b1);
        drain();

        // Credit limit with backpressure, then in-order drain
        rsp_ready = 1'b0;
        fetch(16'h0000, 16'h3412);
        fetch(16'h0002, 16'h7856);
        req_valid = 1'b1; req_addr = 16'h0004;
        repeat (4) @(negedge clk);
        chk("credit_req_ready", req_ready, 1'b0);
        chk("credit_rsp_valid", rsp_valid, 1'b1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        fetch(16'h0004, 16'hBC9A);
        drain();

        // Address wrap
        load(16'hFFFF, 8'hAA); load(16'h0000, 8'hBB);
        fetch(16'hFFFF, 16'hBBAA);
        drain();

        // Flush with two in flight
        fetch(16'h0002, 16'h7856);
        fetch(16'h0004, 16'hBC9A);
        flush = 1'b1;
        exp_q.delete();
        @(negedge clk); chk("flush_req_ready", req_ready, 1'b0);
        tick();
        flush = 1'b0;
        highs = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) highs++;
        end
        chk("flush_no_rsp", highs, 0);
        tick();
        fetch(16'h0002, 16'h7856);
        @(negedge clk); chk("postflush_c1", rsp_valid, 1'b0);
        @(negedge clk); chk("postflush_c2", rsp_valid, 1'b0);
        @(negedge clk); chk("postflush_c3", rsp_valid, 1'b1);
        drain();

        // Load blocks requests; new bytes visible afterwards
        req_valid = 1'b1; req_addr = 16'h0006;
        ld_en = 1'b1; ld_addr = 16'h0006; ld_data = 8'h5A;
        @(negedge clk); chk("load_req_ready", req_ready, 1'b0);
        tick();
        ld_addr = 16'h0007; ld_data = 8'hC3;
        @(negedge clk); chk("load_req_ready2", req_ready, 1'b0);
        tick();
        ld_en = 1'b0; req_valid = 1'b0;
        repeat (4) tick();
        chk("load_no_accept", rsp_valid, 1'b0);
        fetch(16'h0006, 16'hC35A);
        drain();

        // Reset mid-stream
        rsp_ready = 1'b0;
        fetch(16'h0002, 16'h7856);
        wait_rsp_valid();
        #2 rst = 1'b0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_rsp_data", rsp_data, 16'h0000);
        chk("midrst_req_ready", req_ready, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        tick();

        // 3 delivered, 4 stall cycles
        fetch(16'h0002, 16'h7856);
        fetch(16'h0004, 16'hBC9A);
        wait_rsp_valid();
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        fetch(16'h0006, 16'hC35A);
        drain();
        repeat (2) tick();
        chk("final_rsp_valid", rsp_valid, 1'b0);
`ifdef IMEM_STATS_EN
        chk("stat_served", stat_served, 16'd3);
        chk("stat_stall", stat_stall, 16'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
